// File: rtl/rr_arb_hold_pkg.sv
// Shared types and constants for the round-robin hold arbiter.
// Holds the FSM state encoding, the clog2 helper and the default sizes.
package rr_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int N_DEF        = 4;
  localparam int MAX_HOLD_DEF = 15;

  // Never returns less than 1 so that derived vectors always exist.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_arb_hold_if.sv
// Request/grant bundle between the requesters and the arbiter.
// Optional macro RR_ARB_LOCK_EN adds the lock request line.
interface rr_arb_hold_if
  import rr_arb_pkg::*;
#(
  parameter int N = N_DEF
);

  logic [N-1:0]          req;
`ifdef RR_ARB_LOCK_EN
  logic                  lock;
`endif
  logic [N-1:0]          gnt;
  logic                  busy;
  logic [clog2(N)-1:0]   owner;
  logic                  expire;

  modport master (
    output req,
`ifdef RR_ARB_LOCK_EN
    output lock,
`endif
    input  gnt,
    input  busy,
    input  owner,
    input  expire
  );

  modport slave (
    input  req,
`ifdef RR_ARB_LOCK_EN
    input  lock,
`endif
    output gnt,
    output busy,
    output owner,
    output expire
  );

endinterface

// File: rtl/rr_arb_hold_pick.sv
// Combinational rotating priority encoder: first set request bit
// found scanning from ptr upward, wrapping modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          any,
  output logic [PW-1:0] idx
);

  int            j;
  logic [PW-1:0] jj;

  // Scan from the farthest offset down so the nearest set bit wins last.
  always_comb begin
    any = |req;
    idx = ptr;
    j   = 0;
    jj  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j  = (int'(ptr) + i) % N;
      jj = PW'(j);
      if (req[jj]) idx = jj;
    end
  end

endmodule

// File: rtl/rr_arb_hold.sv
// Round-robin arbiter with registered one-hot grant and bounded hold time.
// Optional macro RR_ARB_LOCK_EN: lock input suppresses the hold timeout.
module rr_arb_hold
  import rr_arb_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input logic          ck,
  input logic          nrst,
  rr_arb_hold_if.slave bus
);

  localparam int PW = clog2(N);
  localparam int CW = clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_HOLD - 1);
  localparam logic [PW-1:0] IDX_LAST = PW'(N - 1);

  state_t        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [PW-1:0] owner_q, owner_d;
  logic          expire_q, expire_d;

  logic          pick_any;
  logic [PW-1:0] pick_idx;
  logic          lock_w;
  logic          owner_drop;
  logic          timeout;
  logic [PW-1:0] ptr_after;

`ifdef RR_ARB_LOCK_EN
  assign lock_w = bus.lock;
`else
  assign lock_w = 1'b0;
`endif

  rr_pick #(.N(N), .PW(PW)) u_pick (
    .req (bus.req),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign owner_drop = ~bus.req[owner_q];
  assign timeout    = (cnt_q == CNT_LAST) && !lock_w;
  assign ptr_after  = (owner_q == IDX_LAST) ? '0 : owner_q + PW'(1);

  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      owner_q  <= '0;
      expire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      owner_q  <= owner_d;
      expire_q <= expire_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pick_any) state_d = GRANT;
      GRANT:   if (owner_drop || timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A drop takes precedence over a coincident timeout, so no expire then.
  always_comb begin
    gnt_d    = '0;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    expire_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d[pick_idx] = 1'b1;
          owner_d         = pick_idx;
          cnt_d           = '0;
        end
      end
      GRANT: begin
        if (owner_drop) begin
          ptr_d = ptr_after;
        end else if (timeout) begin
          ptr_d    = ptr_after;
          expire_d = 1'b1;
        end else begin
          gnt_d = gnt_q;
          if (cnt_q != CNT_LAST) cnt_d = cnt_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

  assign bus.gnt    = gnt_q;
  assign bus.busy   = |gnt_q;
  assign bus.owner  = owner_q;
  assign bus.expire = expire_q;

endmodule

// File: doc/rr_arb_hold.md
Name: rr_arb_hold

Overview:
- Round-robin arbiter that shares one downstream resource (pad driver, shared bus segment or gated datapath) among N requesters.
- Issues a registered one-hot grant. Each grant is held for as long as the owner keeps its request asserted, up to a maximum hold time.
- Built purely from library flops and simple gates, so it maps directly onto the standard-cell set.
- Sits between requesting blocks and the AND-style enable gating of the shared resource: gnt[k] drives the enable leg of requester k's gate.

Parameters:
- N, 4, number of requesters (2..8).
- MAX_HOLD, 15, maximum consecutive cycles a single grant may be held (1..255).
- CW, derived as clog2(MAX_HOLD+1), hold counter width; not user-set.

Ports:
- ck  input  1  clock; all state updates on the rising edge.
- nrst  input  1  asynchronous active-low reset.
- req  input  N  request vector; bit k high means requester k wants the resource.
- gnt  output  N  registered one-hot grant; all zero when no owner.
- busy  output  1  high whenever any gnt bit is high.
- owner  output  clog2(N)  index of the current grantee; value is only meaningful while busy=1.
- expire  output  1  one-cycle pulse when a grant is revoked by the hold timeout.

Behaviour:
- Reset (nrst low, asynchronous): gnt=0, busy=0, owner=0, expire=0, ptr=0, cnt=0, state=IDLE. Release of nrst is synchronised externally.
- Internal state: round-robin pointer ptr (clog2(N) bits), hold counter cnt (CW bits), state machine with states IDLE and GRANT.
- IDLE:
  - gnt=0.
  - If req!=0 at edge t: winner = first set bit scanning ptr, ptr+1, ..., wrapping modulo N.
  - After edge t: state=GRANT, gnt=onehot(winner), owner=winner, cnt=0.
  - Request-to-grant latency is exactly 1 cycle.
- GRANT, owner's request dropped: if req[owner]=0 at an edge, then after that edge gnt=0, state=IDLE, ptr=(owner+1) mod N.
- GRANT, hold timeout: if req[owner]=1 and cnt=MAX_HOLD-1, then after that edge gnt=0, expire=1 for one cycle, state=IDLE, ptr=(owner+1) mod N.
- GRANT, otherwise: cnt increments and gnt holds. The grant is therefore visible for at most MAX_HOLD cycles.
- Every release costs one dead IDLE cycle before the next grant. This is a fixed guarantee that the resource enable drops between owners.
- Requests from non-owners during GRANT are ignored; they are picked up on the next IDLE arbitration.
- An expired owner that still requests competes normally after the dead cycle. If it is the only requester it wins again.
- owner holds its last value while in IDLE.
- Simultaneous drop of req[owner] and timeout: treated as a normal release, expire=0.
- Pointer wrap: owner=N-1 gives ptr=0.
- Reset asserted mid-grant: gnt drops asynchronously; no expire pulse is produced.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,...,N-1,0,... with one IDLE cycle between grants.

Optional Feature:
- Macro: RR_ARB_LOCK_EN.
- Defined:
  - Adds input port lock (1 bit), placed after req.
  - While in GRANT with lock=1, the hold timeout is suppressed: cnt saturates at MAX_HOLD-1 and expire never fires.
  - Release then happens only when req[owner] drops.
  - lock is ignored in IDLE.
- Undefined: no lock port; timeout always enforced as above.

Decomposition:
- Shared package rr_arb_pkg holds:
  - state enum (IDLE=1'b0, GRANT=1'b1);
  - clog2 constant function;
  - default constants N_DEF=4 and MAX_HOLD_DEF=15.
- One sub-module, rr_pick:
  - purely combinational rotating priority encoder;
  - inputs req[N], ptr; outputs any, idx.
- The top level holds the FSM, counter, pointer and output registers.

Test Plan:
- Reset then single request: req=4'b0100 held → gnt=4'b0100 one cycle later, owner=2, busy=1; drop req → gnt=0 next cycle, ptr=3.
- All-request rotation: req=4'b1111 constant from ptr=0 → grants 0,1,2,3,0 in order, each lasting 15 cycles followed by 1 IDLE cycle, expire pulse at each revocation.
- Short holds: req=4'b0011, requester 0 holds 3 cycles then drops → gnt=4'b0001 for 3 cycles, 1 IDLE, then gnt=4'b0010; expire stays 0.
- Timeout with sole requester: req=4'b1000 constant → gnt high 15 cycles, expire=1 with gnt=0 for 1 cycle, regrant to 3; repeats.
- Async reset mid-grant: nrst pulled low while gnt=4'b0010 → gnt=0, busy=0 immediately without waiting for ck; after release, first arbitration starts from ptr=0.
- Lock feature (RR_ARB_LOCK_EN defined): req=4'b0001, lock=1 held 40 cycles → gnt held 40 cycles, expire never pulses; drop req → gnt=0 next cycle.
